// File: rtl/iir_stim_driver.sv
// Stimulus generator and response monitor around an HLS IIR core using the
// ap_start/ap_ready/ap_done handshake; tracks per-period peak |response|.
module iir_stim_driver #(
    parameter int DATA_W = 20,
    parameter int PERIOD = 1024,
    parameter int AMPL   = 2**16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              dut_start,
    input  logic              dut_ready,
    input  logic              dut_done,
    input  logic [DATA_W-1:0] dut_return,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    output logic [DATA_W-1:0] peak_out,
    output logic              peak_valid,
    output logic [31:0]       sample_count,
    output logic [15:0]       period_count
);
    localparam int IDX_W = $clog2(PERIOD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(PERIOD / 2);
    localparam logic signed [DATA_W-1:0] AMPL_POS = DATA_W'(AMPL);
    localparam logic signed [DATA_W-1:0] AMPL_NEG = -AMPL_POS;

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'd0,
        MODE_STEP    = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_ZERO    = 2'd3
    } mode_e;

    function automatic logic signed [DATA_W-1:0] stim_sample(input mode_e m,
                                                             input logic [IDX_W-1:0] idx);
        logic signed [DATA_W-1:0] s;
        case (m)
            MODE_IMPULSE: s = (idx == '0) ? AMPL_POS : '0;
            MODE_STEP:    s = AMPL_POS;
            MODE_SQUARE:  s = (idx < IDX_HALF) ? AMPL_POS : AMPL_NEG;
            default:      s = '0;
        endcase
        return s;
    endfunction

    // |v| with the most-negative code clamped to the largest positive value.
    function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        if (v == {1'b1, {(DATA_W-1){1'b0}}})
            m = {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[DATA_W-1])
            m = $unsigned(-v);
        else
            m = $unsigned(v);
        return m;
    endfunction

    logic                     start_q, start_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    mode_e                    mode_q, mode_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0]        y_q, y_d;
    logic                     yv_q, yv_d;
    logic [DATA_W-1:0]        peak_q, peak_d;
    logic                     pv_q, pv_d;
    logic [DATA_W-1:0]        max_q, max_d;
    logic [31:0]              scnt_q, scnt_d;
    logic [15:0]              pcnt_q, pcnt_d;

    logic              accept, wrap, boundary;
    logic [DATA_W-1:0] mag, max_fold;

    always_comb begin
        accept   = start_q & dut_ready;
        wrap     = accept && (idx_q == IDX_LAST);
        boundary = wrap || (!start_q && (idx_q == '0));
        start_d  = enable;
        idx_d    = idx_q;
        if (accept)
            idx_d = wrap ? '0 : idx_q + 1'b1;
        mode_d   = boundary ? mode_e'(mode) : mode_q;
        // x is precomputed from the next state so it always matches the held index.
        x_d      = stim_sample(mode_d, idx_d);
        mag      = sat_abs(dut_return);
        max_fold = (dut_done && (mag > max_q)) ? mag : max_q;
        max_d    = wrap ? '0 : max_fold;
        peak_d   = wrap ? max_fold : peak_q;
        pv_d     = wrap;
        y_d      = dut_done ? dut_return : y_q;
        yv_d     = dut_done;
        scnt_d   = accept ? scnt_q + 32'd1 : scnt_q;
        pcnt_d   = wrap ? pcnt_q + 16'd1 : pcnt_q;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            start_q <= 1'b0;
            idx_q   <= '0;
            mode_q  <= MODE_IMPULSE;
            x_q     <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            peak_q  <= '0;
            pv_q    <= 1'b0;
            max_q   <= '0;
            scnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            start_q <= start_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            peak_q  <= peak_d;
            pv_q    <= pv_d;
            max_q   <= max_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign dut_start    = start_q;
    assign x            = x_q;
    assign y_out        = y_q;
    assign y_valid      = yv_q;
    assign peak_out     = peak_q;
    assign peak_valid   = pv_q;
    assign sample_count = scnt_q;
    assign period_count = pcnt_q;

endmodule

// File: tb/tb_iir_stim_driver.sv
// Scenario bench for iir_stim_driver with PERIOD=4, AMPL=0x10000, DATA_W=20.
module tb_iir_stim_driver;
    localparam int DW  = 20;
    localparam int PER = 4;
    localparam logic [DW-1:0] A  = 20'h10000;
    localparam logic [DW-1:0] NA = 20'hF0000;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          dut_start;
    logic          dut_ready = 1'b1;
    logic          dut_done = 1'b0;
    logic [DW-1:0] dut_return = '0;
    logic [DW-1:0] x;
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic [DW-1:0] peak_out;
    logic          peak_valid;
    logic [31:0]   sample_count;
    logic [15:0]   period_count;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_x_q[$];
    logic [DW-1:0] exp_y_q[$];
    logic [DW-1:0] exp_pk_q[$];
    logic [DW-1:0] last_y = '0;

    always #5 ap_clk = ~ap_clk;

    iir_stim_driver #(.DATA_W(DW), .PERIOD(PER), .AMPL(32'h10000)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable), .mode(mode),
        .dut_start(dut_start), .dut_ready(dut_ready), .dut_done(dut_done),
        .dut_return(dut_return), .x(x), .y_out(y_out), .y_valid(y_valid),
        .peak_out(peak_out), .peak_valid(peak_valid),
        .sample_count(sample_count), .period_count(period_count)
    );

    task automatic clk1();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; enable = 1'b1; mode = 2'd2; dut_ready = 1'b1;
        dut_done = 1'b1; dut_return = 20'h12345;
        repeat (3) clk1();
        total++; if (dut_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", dut_start); end
        total++; if (x !== '0) begin bad++; $display("FAIL reset_x: got %h want 0", x); end
        total++; if ({y_out, y_valid} !== '0) begin bad++; $display("FAIL reset_y: got %h/%b want 0/0", y_out, y_valid); end
        total++; if ({peak_out, peak_valid} !== '0) begin bad++; $display("FAIL reset_peak: got %h/%b want 0/0", peak_out, peak_valid); end
        total++; if ({sample_count, period_count} !== '0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", sample_count, period_count); end
        ap_rst = 1'b0; enable = 1'b0; mode = 2'd0; dut_done = 1'b0; dut_return = '0;
        clk1();
        total++; if (x !== A) begin bad++; $display("FAIL reset_first_x: got %h want %h", x, A); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_release_yvalid: got %b want 0", y_valid); end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] ex;
        enable = 1'b1;
        clk1();
        total++; if (dut_start !== 1'b1) begin bad++; $display("FAIL imp_start: got %b want 1", dut_start); end
        total++; if (x !== A) begin bad++; $display("FAIL imp_x0: got %h want %h", x, A); end
        total++; if (sample_count !== 32'd0) begin bad++; $display("FAIL imp_scnt0: got %0d want 0", sample_count); end
        for (int n = 1; n <= 8; n++) begin
            exp_x_q.push_back((n % PER == 0) ? A : '0);
            clk1();
            ex = exp_x_q.pop_front();
            total++; if (x !== ex) begin bad++; $display("FAIL imp_x[%0d]: got %h want %h", n, x, ex); end
            total++; if (sample_count !== 32'(n)) begin bad++; $display("FAIL imp_scnt[%0d]: got %0d want %0d", n, sample_count, n); end
            total++; if (period_count !== 16'(n / PER)) begin bad++; $display("FAIL imp_pcnt[%0d]: got %0d want %0d", n, period_count, n / PER); end
            total++; if (peak_valid !== (n % PER == 0)) begin bad++; $display("FAIL imp_pvalid[%0d]: got %b want %b", n, peak_valid, (n % PER == 0)); end
        end
    endtask

    task automatic test_square();
        logic [DW-1:0] tbl [8];
        logic [DW-1:0] ex;
        tbl[0] = '0; tbl[1] = '0; tbl[2] = '0; tbl[3] = A;
        tbl[4] = A;  tbl[5] = NA; tbl[6] = NA; tbl[7] = A;
        for (int n = 0; n < 8; n++) begin
            exp_x_q.push_back(tbl[n]);
            clk1();
            if (n == 0) mode = 2'd2;
            ex = exp_x_q.pop_front();
            total++; if (x !== ex) begin bad++; $display("FAIL sq_x[%0d]: got %h want %h", n, x, ex); end
        end
        total++; if (period_count !== 16'd4) begin bad++; $display("FAIL sq_pcnt: got %0d want 4", period_count); end
        total++; if (sample_count !== 32'd16) begin bad++; $display("FAIL sq_scnt: got %0d want 16", sample_count); end
    endtask

    task automatic test_backpressure();
        clk1();
        total++; if (x !== A) begin bad++; $display("FAIL bp_x_idx1: got %h want %h", x, A); end
        dut_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clk1();
            total++; if (x !== A) begin bad++; $display("FAIL bp_hold_x[%0d]: got %h want %h", k, x, A); end
            total++; if (sample_count !== 32'd17) begin bad++; $display("FAIL bp_hold_scnt[%0d]: got %0d want 17", k, sample_count); end
        end
        dut_ready = 1'b1;
        clk1();
        total++; if (x !== NA) begin bad++; $display("FAIL bp_resume_x: got %h want %h", x, NA); end
        total++; if (sample_count !== 32'd18) begin bad++; $display("FAIL bp_resume_scnt: got %0d want 18", sample_count); end
        clk1();
        total++; if (x !== NA) begin bad++; $display("FAIL bp_x_idx3: got %h want %h", x, NA); end
        clk1();
        total++; if (x !== A) begin bad++; $display("FAIL bp_x_wrap: got %h want %h", x, A); end
        total++; if (period_count !== 16'd5) begin bad++; $display("FAIL bp_pcnt: got %0d want 5", period_count); end
    endtask

    task automatic test_pause();
        clk1();
        enable = 1'b0; mode = 2'd0;
        clk1();
        total++; if (dut_start !== 1'b0) begin bad++; $display("FAIL pause_start: got %b want 0", dut_start); end
        total++; if (x !== NA) begin bad++; $display("FAIL pause_x: got %h want %h", x, NA); end
        total++; if (sample_count !== 32'd22) begin bad++; $display("FAIL pause_scnt: got %0d want 22", sample_count); end
        for (int k = 0; k < 3; k++) begin
            clk1();
            total++; if (x !== NA) begin bad++; $display("FAIL pause_hold_x[%0d]: got %h want %h", k, x, NA); end
            total++; if (sample_count !== 32'd22) begin bad++; $display("FAIL pause_hold_scnt[%0d]: got %0d want 22", k, sample_count); end
        end
        enable = 1'b1;
        clk1();
        total++; if (dut_start !== 1'b1) begin bad++; $display("FAIL resume_start: got %b want 1", dut_start); end
        total++; if (sample_count !== 32'd22) begin bad++; $display("FAIL resume_scnt: got %0d want 22", sample_count); end
        clk1();
        total++; if (x !== NA) begin bad++; $display("FAIL resume_x_idx3: got %h want %h", x, NA); end
        clk1();
        total++; if (peak_valid !== 1'b1) begin bad++; $display("FAIL resume_pvalid: got %b want 1", peak_valid); end
        total++; if (period_count !== 16'd6) begin bad++; $display("FAIL resume_pcnt: got %0d want 6", period_count); end
        clk1();
        total++; if (x !== '0) begin bad++; $display("FAIL deferred_mode_x: got %h want 0", x); end
        repeat (3) clk1();
        total++; if (x !== A) begin bad++; $display("FAIL pause_end_x: got %h want %h", x, A); end
        total++; if (period_count !== 16'd7) begin bad++; $display("FAIL pause_end_pcnt: got %0d want 7", period_count); end
    endtask

    task automatic test_peak();
        logic          dn [8];
        logic [DW-1:0] rt [8];
        logic [DW-1:0] ek;
        dn = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rt = '{20'h00005, 20'hFFFF0, 20'h00003, 20'h0, 20'h80000, 20'h0, 20'h0, 20'h0};
        for (int n = 0; n < 8; n++) begin
            dut_done = dn[n]; dut_return = rt[n];
            if (dn[n]) exp_y_q.push_back(rt[n]);
            if (n == 3) exp_pk_q.push_back(20'h00010);
            if (n == 7) exp_pk_q.push_back(20'h7FFFF);
            clk1();
            if (dn[n] && exp_y_q.size() > 0) last_y = exp_y_q.pop_front();
            total++; if (y_valid !== dn[n]) begin bad++; $display("FAIL pk_yvalid[%0d]: got %b want %b", n, y_valid, dn[n]); end
            total++; if (y_out !== last_y) begin bad++; $display("FAIL pk_yout[%0d]: got %h want %h", n, y_out, last_y); end
            total++; if (peak_valid !== (n == 3 || n == 7)) begin bad++; $display("FAIL pk_pvalid[%0d]: got %b want %b", n, peak_valid, (n == 3 || n == 7)); end
            if (peak_valid && exp_pk_q.size() > 0) begin
                ek = exp_pk_q.pop_front();
                total++; if (peak_out !== ek) begin bad++; $display("FAIL pk_peak[%0d]: got %h want %h", n, peak_out, ek); end
            end
        end
        dut_done = 1'b0; dut_return = '0;
        total++; if (exp_pk_q.size() != 0) begin bad++; $display("FAIL pk_missing: got %0d left want 0", exp_pk_q.size()); end
        total++; if (sample_count !== 32'd36) begin bad++; $display("FAIL pk_scnt: got %0d want 36", sample_count); end
    endtask

    task automatic test_back_to_back();
        logic          dn [8];
        logic [DW-1:0] rt [8];
        logic [DW-1:0] ek;
        dn = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        rt = '{20'h0, 20'h00007, 20'h0, 20'h00020, 20'h0, 20'h00002, 20'h0, 20'h0};
        for (int n = 0; n < 8; n++) begin
            dut_done = dn[n]; dut_return = rt[n];
            if (dn[n]) exp_y_q.push_back(rt[n]);
            if (n == 3) exp_pk_q.push_back(20'h00020);
            if (n == 7) exp_pk_q.push_back(20'h00002);
            clk1();
            if (dn[n] && exp_y_q.size() > 0) last_y = exp_y_q.pop_front();
            total++; if (y_valid !== dn[n]) begin bad++; $display("FAIL b2b_yvalid[%0d]: got %b want %b", n, y_valid, dn[n]); end
            total++; if (y_out !== last_y) begin bad++; $display("FAIL b2b_yout[%0d]: got %h want %h", n, y_out, last_y); end
            total++; if (peak_valid !== (n == 3 || n == 7)) begin bad++; $display("FAIL b2b_pvalid[%0d]: got %b want %b", n, peak_valid, (n == 3 || n == 7)); end
            if (peak_valid && exp_pk_q.size() > 0) begin
                ek = exp_pk_q.pop_front();
                total++; if (peak_out !== ek) begin bad++; $display("FAIL b2b_peak[%0d]: got %h want %h", n, peak_out, ek); end
            end
        end
        dut_done = 1'b0; dut_return = '0;
        total++; if (period_count !== 16'd11) begin bad++; $display("FAIL b2b_pcnt: got %0d want 11", period_count); end
        repeat (2) clk1();
        ap_rst = 1'b1; dut_done = 1'b1; dut_return = 20'h40000;
        clk1();
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_pvalid: got %b want 0", peak_valid); end
        total++; if ({dut_start, x, y_out, y_valid, peak_out} !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %b/%h/%h/%b/%h want all 0", dut_start, x, y_out, y_valid, peak_out); end
        total++; if ({sample_count, period_count} !== '0) begin bad++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", sample_count, period_count); end
        ap_rst = 1'b0; dut_done = 1'b0; dut_return = '0;
        clk1();
        total++; if (x !== A) begin bad++; $display("FAIL rst_rel_x: got %h want %h", x, A); end
        total++; if (dut_start !== 1'b1) begin bad++; $display("FAIL rst_rel_start: got %b want 1", dut_start); end
        total++; if ({y_out, y_valid} !== '0) begin bad++; $display("FAIL rst_rel_y: got %h/%b want 0/0", y_out, y_valid); end
        for (int k = 1; k <= 4; k++) begin
            clk1();
            total++; if (peak_valid !== (k == 4)) begin bad++; $display("FAIL rst_period_pvalid[%0d]: got %b want %b", k, peak_valid, (k == 4)); end
        end
        total++; if (peak_out !== '0) begin bad++; $display("FAIL rst_period_peak: got %h want 0", peak_out); end
        total++; if (period_count !== 16'd1) begin bad++; $display("FAIL rst_period_pcnt: got %0d want 1", period_count); end
        total++; if (sample_count !== 32'd4) begin bad++; $display("FAIL rst_period_scnt: got %0d want 4", sample_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_impulse();
        test_square();
        test_backpressure();
        test_pause();
        test_peak();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
